// File: rtl/rv32v_load_collector.sv
// Collects per-lane LSC load returns into one NUM_LANES-wide micro-op result for VRF writeback.
// Optional RV32V_LOAD_COLLECT_BYPASS_EN: accept the next start on the writeback handshake cycle.
module rv32v_load_collector #(
    parameter int NUM_LANES = 2,
    parameter int WORD_W    = 32
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic                          flush,
    input  logic                          start,
    input  logic [NUM_LANES-1:0]          start_mask,
    input  logic [4:0]                    start_uop_num,
    input  logic [4:0]                    start_vd,
    input  logic                          load_valid,
    input  logic [$clog2(NUM_LANES)-1:0]  load_lane,
    input  logic [WORD_W-1:0]             load_data,
    output logic                          wb_valid,
    input  logic                          wb_ready,
    output logic [4:0]                    wb_vd,
    output logic [4:0]                    wb_uop_num,
    output logic [NUM_LANES-1:0]          wb_mask,
    output logic [NUM_LANES*WORD_W-1:0]   wb_data,
    output logic                          busy,
    output logic                          proto_err
);
    localparam int LANE_W = $clog2(NUM_LANES);

    typedef enum logic [1:0] {IDLE, COLLECT, WB} state_t;

    state_t               state_q, state_d;
    logic [NUM_LANES-1:0] pending_q;
    logic [NUM_LANES-1:0] lane_bit;
    logic [WORD_W-1:0]    data_q [NUM_LANES];
    logic                 take_start, accept, err_d;

    assign lane_bit = {{(NUM_LANES-1){1'b0}}, 1'b1} << load_lane;

    always_comb begin
        state_d    = state_q;
        take_start = 1'b0;
        accept     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                err_d = load_valid;
                if (start) begin
                    take_start = 1'b1;
                    state_d    = (|start_mask) ? COLLECT : WB;
                end
            end
            COLLECT: begin
                if (load_valid) begin
                    if (|(pending_q & lane_bit)) begin
                        accept = 1'b1;
                        if ((pending_q & ~lane_bit) == '0) state_d = WB;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WB: begin
                err_d = load_valid;
                if (wb_ready) begin
                    state_d = IDLE;
`ifdef RV32V_LOAD_COLLECT_BYPASS_EN
                    if (start) begin
                        take_start = 1'b1;
                        state_d    = (|start_mask) ? COLLECT : WB;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush beats the last load and the handshake; latched outputs are left as-is.
        if (flush) begin
            state_d    = IDLE;
            take_start = 1'b0;
            accept     = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            wb_vd      <= '0;
            wb_uop_num <= '0;
            wb_mask    <= '0;
            proto_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (err_d) proto_err <= 1'b1;
            if (flush) begin
                pending_q <= '0;
            end else if (take_start) begin
                pending_q  <= start_mask;
                wb_vd      <= start_vd;
                wb_uop_num <= start_uop_num;
                wb_mask    <= start_mask;
            end else if (accept) begin
                pending_q <= pending_q & ~lane_bit;
            end
        end
    end

    // Masked lanes stay zero because every start clears all slots.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST)
                data_q[i] <= '0;
            else if (take_start)
                data_q[i] <= '0;
            else if (accept && load_lane == LANE_W'(i))
                data_q[i] <= load_data;
        end
        assign wb_data[i*WORD_W +: WORD_W] = data_q[i];
    end

    assign wb_valid = (state_q == WB);
    assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_rv32v_load_collector.sv
// Directed bench for rv32v_load_collector (NUM_LANES=2, WORD_W=32).
module tb_rv32v_load_collector;
    logic        CLK, nRST, flush, start, load_valid, load_lane, wb_ready;
    logic [1:0]  start_mask;
    logic [4:0]  start_uop_num, start_vd;
    logic [31:0] load_data;
    logic        wb_valid, busy, proto_err;
    logic [4:0]  wb_vd, wb_uop_num;
    logic [1:0]  wb_mask;
    logic [63:0] wb_data;
    int n_cmp = 0;
    int n_err = 0;

    rv32v_load_collector #(.NUM_LANES(2), .WORD_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush), .start(start), .start_mask(start_mask),
        .start_uop_num(start_uop_num), .start_vd(start_vd), .load_valid(load_valid),
        .load_lane(load_lane), .load_data(load_data), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_vd(wb_vd), .wb_uop_num(wb_uop_num), .wb_mask(wb_mask), .wb_data(wb_data),
        .busy(busy), .proto_err(proto_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; start_mask = 0; start_vd = 0; start_uop_num = 0;
        load_valid = 0; load_lane = 0; load_data = 0; flush = 0; wb_ready = 0;
    endtask

    task automatic do_start(input logic [1:0] m, input logic [4:0] vd, input logic [4:0] uop);
        start = 1; start_mask = m; start_vd = vd; start_uop_num = uop;
        step();
        start = 0; start_mask = 0;
    endtask

    task automatic do_load(input logic ln, input logic [31:0] d);
        load_valid = 1; load_lane = ln; load_data = d;
        step();
        load_valid = 0;
    endtask

    task automatic test_reset();
        n_cmp++; if (wb_valid !== 0 || busy !== 0 || proto_err !== 0) begin
            n_err++; $display("FAIL reset_ctrl: got v=%b b=%b e=%b expected 0 0 0", wb_valid, busy, proto_err); end
        n_cmp++; if ({wb_vd, wb_uop_num, wb_mask, wb_data} !== '0) begin
            n_err++; $display("FAIL reset_data: got vd=%h uop=%h m=%b d=%h expected all 0", wb_vd, wb_uop_num, wb_mask, wb_data); end
        nRST = 1;
        step();
        // asynchronous reset in the middle of a collection
        do_start(2'b11, 5'd7, 5'd2);
        do_load(1'b0, 32'hAAAA5555);
        #2 nRST = 0;
        #1;
        n_cmp++; if (busy !== 0 || wb_valid !== 0 || wb_vd !== 0 || wb_mask !== 0 || wb_data !== 0) begin
            n_err++; $display("FAIL reset_async: got b=%b v=%b vd=%h m=%b d=%h expected all 0", busy, wb_valid, wb_vd, wb_mask, wb_data); end
        #3 nRST = 1;
        step(); step(); step();
        n_cmp++; if (wb_valid !== 0 || busy !== 0) begin
            n_err++; $display("FAIL reset_after: got v=%b b=%b expected 0 0", wb_valid, busy); end
    endtask

    task automatic test_normal();
        do_start(2'b11, 5'd8, 5'd3);
        n_cmp++; if (busy !== 1 || wb_valid !== 0) begin
            n_err++; $display("FAIL norm_collect: got b=%b v=%b expected 1 0", busy, wb_valid); end
        do_load(1'b0, 32'hDEADBEEF);
        n_cmp++; if (wb_valid !== 0) begin
            n_err++; $display("FAIL norm_early_valid: got %b expected 0", wb_valid); end
        do_load(1'b1, 32'h12345678);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (wb_valid !== 1 || wb_data !== 64'h12345678_DEADBEEF || wb_vd !== 5'd8 ||
                         wb_uop_num !== 5'd3 || wb_mask !== 2'b11) begin
                n_err++; $display("FAIL norm_wb[%0d]: got v=%b d=%h vd=%0d uop=%0d m=%b expected 1 12345678deadbeef 8 3 11",
                                  i, wb_valid, wb_data, wb_vd, wb_uop_num, wb_mask); end
            if (i < 3) step();
        end
        wb_ready = 1; step(); wb_ready = 0;
        n_cmp++; if (wb_valid !== 0 || busy !== 0) begin
            n_err++; $display("FAIL norm_idle: got v=%b b=%b expected 0 0", wb_valid, busy); end
    endtask

    task automatic test_masked();
        do_start(2'b10, 5'd4, 5'd1);
        do_load(1'b1, 32'hCAFEF00D);
        n_cmp++; if (wb_valid !== 1 || wb_data !== 64'hCAFEF00D_00000000 || proto_err !== 0) begin
            n_err++; $display("FAIL mask_10: got v=%b d=%h e=%b expected 1 cafef00d00000000 0", wb_valid, wb_data, proto_err); end
        wb_ready = 1; step(); wb_ready = 0;
        do_start(2'b00, 5'd5, 5'd6);
        n_cmp++; if (wb_valid !== 1 || wb_data !== 64'h0 || wb_mask !== 2'b00 || wb_vd !== 5'd5) begin
            n_err++; $display("FAIL mask_00: got v=%b d=%h m=%b vd=%0d expected 1 0 00 5", wb_valid, wb_data, wb_mask, wb_vd); end
        wb_ready = 1; step(); wb_ready = 0;
        n_cmp++; if (busy !== 0) begin
            n_err++; $display("FAIL mask_00_idle: got b=%b expected 0", busy); end
    endtask

    task automatic test_proto_err();
        do_start(2'b01, 5'd10, 5'd0);
        do_load(1'b1, 32'h1);
        n_cmp++; if (proto_err !== 1 || wb_valid !== 0 || busy !== 1) begin
            n_err++; $display("FAIL proto_set: got e=%b v=%b b=%b expected 1 0 1", proto_err, wb_valid, busy); end
        do_load(1'b0, 32'h5);
        n_cmp++; if (wb_valid !== 1 || wb_data !== 64'h00000000_00000005 || proto_err !== 1) begin
            n_err++; $display("FAIL proto_done: got v=%b d=%h e=%b expected 1 0000000000000005 1", wb_valid, wb_data, proto_err); end
        wb_ready = 1; step(); wb_ready = 0;
    endtask

    task automatic test_flush();
        do_start(2'b11, 5'd12, 5'd9);
        do_load(1'b0, 32'h11111111);
        flush = 1;
        do_load(1'b1, 32'h22222222);
        flush = 0;
        n_cmp++; if (wb_valid !== 0 || busy !== 0 || wb_vd !== 5'd12) begin
            n_err++; $display("FAIL flush_last: got v=%b b=%b vd=%0d expected 0 0 12", wb_valid, busy, wb_vd); end
        step();
        n_cmp++; if (wb_valid !== 0) begin
            n_err++; $display("FAIL flush_no_wb: got %b expected 0", wb_valid); end
        do_start(2'b01, 5'd2, 5'd1);
        do_load(1'b0, 32'h0000000A);
        n_cmp++; if (wb_valid !== 1 || wb_data !== 64'h0000000A || wb_vd !== 5'd2 || wb_uop_num !== 5'd1) begin
            n_err++; $display("FAIL flush_restart: got v=%b d=%h vd=%0d uop=%0d expected 1 a 2 1", wb_valid, wb_data, wb_vd, wb_uop_num); end
        wb_ready = 1; step(); wb_ready = 0;
    endtask

    task automatic test_back_to_back();
        do_start(2'b01, 5'd3, 5'd3);
        do_load(1'b0, 32'h77);
        wb_ready = 1; start = 1; start_mask = 2'b01; start_vd = 5'd9; start_uop_num = 5'd4;
        step();
        wb_ready = 0; start = 0; start_mask = 0;
`ifdef RV32V_LOAD_COLLECT_BYPASS_EN
        n_cmp++; if (busy !== 1 || wb_valid !== 0 || wb_vd !== 5'd9 || wb_data !== 64'h0) begin
            n_err++; $display("FAIL bypass_on: got b=%b v=%b vd=%0d d=%h expected 1 0 9 0", busy, wb_valid, wb_vd, wb_data); end
        do_load(1'b0, 32'h99);
        n_cmp++; if (wb_valid !== 1 || wb_data !== 64'h99 || wb_uop_num !== 5'd4) begin
            n_err++; $display("FAIL bypass_wb: got v=%b d=%h uop=%0d expected 1 99 4", wb_valid, wb_data, wb_uop_num); end
        wb_ready = 1; step(); wb_ready = 0;
`else
        n_cmp++; if (busy !== 0 || wb_valid !== 0 || wb_vd !== 5'd3 || wb_data !== 64'h77) begin
            n_err++; $display("FAIL bypass_off: got b=%b v=%b vd=%0d d=%h expected 0 0 3 77", busy, wb_valid, wb_vd, wb_data); end
`endif
        n_cmp++; if (proto_err !== 1) begin
            n_err++; $display("FAIL proto_sticky: got %b expected 1", proto_err); end
    endtask

    initial begin
        idle_inputs();
        nRST = 0;
        #1;
        test_reset();
        test_normal();
        test_masked();
        test_proto_err();
        test_flush();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
